// File: rtl/sorteio_loteria.sv
// ============================================================================
// Module   : sorteio_loteria
// Brief    : Draws a five-digit BCD number from a free-running LFSR and sends it
//            digit by digit on the num/insert/finish checker interface.
//            Build option: SORTEIO_FIXED_EN loads the house number 5-0-9-6-7.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sorteio_loteria #(
    parameter int          GAP  = 4,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  num,
    output logic        insert,
    output logic        finish,
    output logic        busy,
    output logic        done,
    output logic [19:0] digits
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DRAW = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] c_SEED     = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  c_GAP_LAST = 4'(GAP - 1);

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [2:0]  r_idx;
    logic [3:0]  r_gap_cnt;
    logic [3:0]  r_slot [5];
    logic [3:0]  r_num;
    logic        r_insert;
    logic        r_finish;
    logic        r_busy;
    logic        r_done;

    logic        w_fb;
    logic [2:0]  w_idx_nxt;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1, shifting left.
    assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_idx_nxt = r_idx + 3'd1;

`ifndef SORTEIO_FIXED_EN
    logic [3:0] w_sample;
    assign w_sample = r_lfsr[3:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lfsr    <= c_SEED;
            r_idx     <= 3'd0;
            r_gap_cnt <= 4'd0;
            for (int i = 0; i < 5; i++) begin
                r_slot[i] <= 4'd0;
            end
            r_num     <= 4'd0;
            r_insert  <= 1'b0;
            r_finish  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_lfsr   <= {r_lfsr[14:0], w_fb};
            r_insert <= 1'b0;
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_DRAW;
                        r_idx   <= 3'd0;
                        for (int i = 0; i < 5; i++) begin
                            r_slot[i] <= 4'd0;
                        end
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_DRAW: begin
`ifdef SORTEIO_FIXED_EN
                    r_slot[0] <= 4'd5;
                    r_slot[1] <= 4'd0;
                    r_slot[2] <= 4'd9;
                    r_slot[3] <= 4'd6;
                    r_slot[4] <= 4'd7;
                    r_idx     <= 3'd0;
                    r_num     <= 4'd5;
                    r_insert  <= 1'b1;
                    r_state   <= S_SEND;
`else
                    // Samples of 10..15 are dropped so every digit stays BCD.
                    if (w_sample <= 4'd9) begin
                        r_slot[r_idx] <= w_sample;
                        if (r_idx == 3'd4) begin
                            r_idx    <= 3'd0;
                            r_num    <= r_slot[0];
                            r_insert <= 1'b1;
                            r_state  <= S_SEND;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end
`endif
                end
                S_SEND: begin
                    r_gap_cnt <= c_GAP_LAST;
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap_cnt != 4'd0) begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end else if (r_idx == 3'd4) begin
                        r_finish <= 1'b1;
                        r_state  <= S_FIN;
                    end else begin
                        r_idx    <= w_idx_nxt;
                        r_num    <= r_slot[w_idx_nxt];
                        r_insert <= 1'b1;
                        r_state  <= S_SEND;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign num    = r_num;
    assign insert = r_insert;
    assign finish = r_finish;
    assign busy   = r_busy;
    assign done   = r_done;
    assign digits = {r_slot[0], r_slot[1], r_slot[2], r_slot[3], r_slot[4]};

endmodule

`default_nettype wire
